// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Load/store sequencer between the memory-stage request and a
//            word-only data memory (combinational read, synchronous write).
//            Loads extract and extend byte/half/word lanes; SB/SH run as a
//            two-access read-modify-write; misaligned, illegal or
//            out-of-range requests are answered with an error and never
//            touch memory.
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err
//            mem_re/mem_we/mem_addr/mem_wdata/mem_rdata
//            stat_loads/stat_stores/stat_errs (only with
//            LSU_MEM_CTRL_STATS_EN defined)
// Options  : `define LSU_MEM_CTRL_STATS_EN adds saturating response counters.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 256,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef LSU_MEM_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_loads,
    output logic [CNT_W-1:0] stat_stores,
    output logic [CNT_W-1:0] stat_errs
`endif
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_RMW_RD = 3'd2;
    localparam logic [2:0] c_WRITE  = 3'd3;
    localparam logic [2:0] c_RESP   = 3'd4;
    localparam logic [2:0] c_ERR    = 3'd5;

    // First illegal byte address, held in 33 bits so 4*MEM_WORDS = 2^32 works.
    localparam logic [32:0] c_ADDR_LIMIT = {1'b0, 32'(MEM_WORDS)} << 2;

    logic [2:0]  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;

    logic        w_legal_code;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_legal;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    // ------------------------------------------------------------------
    // Legality of the request presented on the req_* inputs
    // ------------------------------------------------------------------
    always_comb begin
        w_legal_code = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_legal_code = 1'b1;
                default:                w_legal_code = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal_code = 1'b1;
                default:                                w_legal_code = 1'b0;
            endcase
        end

        // funct3[1:0] encodes the access size for every legal code
        w_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase

        w_out_of_range = ({1'b0, req_addr} >= c_ADDR_LIMIT);
        w_legal        = w_legal_code & ~w_misaligned & ~w_out_of_range;
    end

    // ------------------------------------------------------------------
    // Load lane extraction and store lane merge
    // ------------------------------------------------------------------
    always_comb begin
        w_shifted = mem_rdata >> {r_addr_lo, 3'b000};
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'b0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'b0, w_shifted[15:0]};
            default: w_load_data = w_shifted;   // LW: aligned, shift is zero
        endcase

        w_merge = mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            w_merge[{r_addr_lo, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_addr_lo[1]) begin
            w_merge[31:16] = r_wdata;
        end else begin
            w_merge[15:0] = r_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_wdata     <= 16'h0000;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_rdata     <= 32'h0000_0000;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        r_wdata   <= req_wdata[15:0];
                        r_rdata   <= 32'h0000_0000;   // stores and errors return 0
                        if (!w_legal) begin
                            r_state <= c_ERR;
                        end else begin
                            r_mem_addr <= {req_addr[31:2], 2'b00};
                            if (!req_we) begin
                                r_state <= c_LOAD;
                            end else if (req_funct3[1:0] == 2'b10) begin
                                r_mem_wdata <= req_wdata;
                                r_state     <= c_WRITE;
                            end else begin
                                r_state <= c_RMW_RD;
                            end
                        end
                    end
                end
                c_LOAD: begin
                    r_rdata <= w_load_data;
                    r_state <= c_RESP;
                end
                c_RMW_RD: begin
                    r_mem_wdata <= w_merge;
                    r_state     <= c_WRITE;
                end
                c_WRITE: begin
                    r_state <= c_RESP;
                end
                c_RESP, c_ERR: begin
                    // Returning to IDLE first means a request waiting during
                    // the handshake is taken one cycle later, never the same edge.
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Memory strobes come from the state register alone, so asserting
    // rst_n cancels a pending write in the same instant.
    assign req_ready = (r_state == c_IDLE);
    assign mem_re    = (r_state == c_LOAD) | (r_state == c_RMW_RD);
    assign mem_we    = (r_state == c_WRITE);
    assign rsp_valid = (r_state == c_RESP) | (r_state == c_ERR);
    assign rsp_err   = (r_state == c_ERR);
    assign rsp_rdata = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

`ifdef LSU_MEM_CTRL_STATS_EN
    // ------------------------------------------------------------------
    // Saturating response counters
    // ------------------------------------------------------------------
    logic             r_we;
    logic [CNT_W-1:0] r_stat_loads;
    logic [CNT_W-1:0] r_stat_stores;
    logic [CNT_W-1:0] r_stat_errs;
    logic             w_rsp_done;

    assign w_rsp_done = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we          <= 1'b0;
            r_stat_loads  <= '0;
            r_stat_stores <= '0;
            r_stat_errs   <= '0;
        end else begin
            if ((r_state == c_IDLE) && req_valid) begin
                r_we <= req_we;
            end
            if (w_rsp_done) begin
                if (r_state == c_ERR) begin
                    if (~&r_stat_errs)   r_stat_errs   <= r_stat_errs + 1'b1;
                end else if (r_we) begin
                    if (~&r_stat_stores) r_stat_stores <= r_stat_stores + 1'b1;
                end else begin
                    if (~&r_stat_loads)  r_stat_loads  <= r_stat_loads + 1'b1;
                end
            end
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_errs   = r_stat_errs;
`else
    // Statistics absent; CNT_W has no effect in this build.
    generate
        if (CNT_W > 0) begin : g_no_stats
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Self-checking bench for lsu_mem_ctrl with a behavioural
//            word memory (combinational read, synchronous write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LSU_MEM_CTRL_STATS_EN
    logic [15:0] stat_loads;
    logic [15:0] stat_stores;
    logic [15:0] stat_errs;
`endif

    lsu_mem_ctrl #(.MEM_WORDS(MEM_WORDS), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef LSU_MEM_CTRL_STATS_EN
        ,
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errs  (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:MEM_WORDS-1];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    logic overlap_seen = 1'b0;
    always @(negedge clk) begin
        if (mem_re && mem_we) overlap_seen = 1'b1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] mwdata;
    } vec_t;

    vec_t vecs[$];

    task automatic run_req(input vec_t v, input string tag);
        int n_re;
        int n_we;
        int cyc;
        logic [31:0] wd_seen;
        logic addr_ok;
        logic exp_re;
        logic exp_we;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_re = 0; n_we = 0; wd_seen = 32'h0; addr_ok = 1'b1;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (mem_re) n_re++;
            if (mem_we) begin
                n_we++;
                wd_seen = mem_wdata;
            end
            if ((mem_re || mem_we) && (mem_addr !== {v.addr[31:2], 2'b00})) addr_ok = 1'b0;
            if (rsp_valid) break;
        end
        exp_re = !v.err && (!v.we || (v.f3[1:0] != 2'b10));
        exp_we = !v.err && v.we;
        chk({tag, " latency"}, 32'(cyc), 32'(v.lat));
        chk({tag, " rsp_err"}, {31'b0, rsp_err}, {31'b0, v.err});
        chk({tag, " rsp_rdata"}, rsp_rdata, v.rdata);
        chk({tag, " mem_re cycles"}, 32'(n_re), {31'b0, exp_re});
        chk({tag, " mem_we cycles"}, 32'(n_we), {31'b0, exp_we});
        chk({tag, " mem_addr"}, {31'b0, addr_ok}, 32'h1);
        if (exp_we) chk({tag, " mem_wdata"}, wd_seen, v.mwdata);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int cyc;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        mem[4]   = 32'h8899AABB;
        mem[255] = 32'h80000000;

        //           we    f3      addr        wdata        err   rdata        lat mwdata
        vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0,        1'b0, 32'h8899AABB, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h011, 32'h0,        1'b0, 32'hFFFFFFAA, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b100, 32'h011, 32'h0,        1'b0, 32'h000000AA, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b101, 32'h012, 32'h0,        1'b0, 32'h00008899, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h012, 32'h0,        1'b0, 32'hFFFF8899, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h013, 32'h0,        1'b0, 32'hFFFFFF88, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b100, 32'h010, 32'h0,        1'b0, 32'h000000BB, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h3FF, 32'h0,        1'b0, 32'hFFFFFF80, 2, 32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h012, 32'h123456CC, 1'b0, 32'h0,        3, 32'h88CCAABB});
        vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0,        1'b0, 32'h88CCAABB, 2, 32'h0});
        vecs.push_back('{1'b1, 3'b001, 32'h010, 32'hFFFF1234, 1'b0, 32'h0,        3, 32'h88CC1234});
        vecs.push_back('{1'b0, 3'b001, 32'h010, 32'h0,        1'b0, 32'h00001234, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h012, 32'h0,        1'b0, 32'hFFFF88CC, 2, 32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h013, 32'h0000007F, 1'b0, 32'h0,        3, 32'h7FCC1234});
        vecs.push_back('{1'b0, 3'b000, 32'h013, 32'h0,        1'b0, 32'h0000007F, 2, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h020, 32'hDEADBEEF, 1'b0, 32'h0,        2, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 3'b010, 32'h020, 32'h0,        1'b0, 32'hDEADBEEF, 2, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h013, 32'h0,        1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h402, 32'h11111111, 1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h400, 32'h0,        1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b0, 3'b100, 32'h400, 32'h0,        1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b0, 3'b011, 32'h010, 32'h0,        1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b1, 3'b100, 32'h010, 32'h22222222, 1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b0, 3'b110, 32'h010, 32'h0,        1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h001, 32'h33333333, 1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b1, 3'b001, 32'h021, 32'h44444444, 1'b1, 32'h0,        1, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h3FC, 32'h0,        1'b0, 32'h80000000, 2, 32'h0});

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset handshake outs", {28'b0, req_ready, rsp_valid, rsp_err, mem_re}, 32'h8);
        chk("reset mem_we", {31'b0, mem_we}, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: LW held for 5 cycles while another request waits.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_funct3 = 3'b100; req_addr = 32'h20;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("bp latency", 32'(cyc), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ok = rsp_valid && !rsp_err && !req_ready && !mem_re && !mem_we && (rsp_rdata === 32'h7FCC1234);
            chk($sformatf("bp hold cycle %0d", k), {31'b0, ok}, 32'h1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("bp no same-edge accept", {30'b0, req_ready, rsp_valid}, 32'h2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("bp queued req mem_re", {31'b0, mem_re}, 32'h1);
        chk("bp queued req mem_addr", mem_addr, 32'h20);
        @(negedge clk);
        chk("bp queued req rsp", {31'b0, rsp_valid}, 32'h1);
        chk("bp queued req rdata", rsp_rdata, 32'h000000EF);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Reset during RMW_RD of SB 0x10.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rst-mid rmw mem_re", {31'b0, mem_re}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst-mid outs", {27'b0, req_ready, rsp_valid, rsp_err, mem_re, mem_we}, 32'h10);
        chk("rst-mid mem_addr", mem_addr, 32'h0);
        chk("rst-mid mem_wdata", mem_wdata, 32'h0);
        chk("rst-mid rsp_rdata", rsp_rdata, 32'h0);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_we) ok = 1'b0;
        end
        chk("rst-mid no write", {31'b0, ok}, 32'h1);
        rst_n = 1'b1;
        chk("rst-mid memory intact", mem[4], 32'h7FCC1234);
        run_req('{1'b0, 3'b010, 32'h010, 32'h0, 1'b0, 32'h7FCC1234, 2, 32'h0}, "post-reset LW");

        chk("re/we exclusive", {31'b0, overlap_seen}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
